calc_alu_arbiter: RTL
=====================

Name: calc_alu_arbiter

Overview:
- Shares one multi-cycle calculator arithmetic unit (operands/results of type calc_pkg::num_t) between NumReq requesters, e.g. the keypad front-end and the memory-recall/constant path.
- Round-robin arbitration; one operation in flight at a time.
- Drives the unit with a start/done handshake and returns the result to the owning requester with a valid/ready handshake.

Parameters:
- NumReq, 2, number of requesters (2..4).
- OpWidth, 2, width of the op code (0 add, 1 sub, 2 mul, 3 div); passed through unmodified.
- TimeoutCycles, 64, watchdog limit in clk_i cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous, active-high.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester accept; at most one bit high.
- req_op_i  in  NumReq x OpWidth  op code per requester.
- req_a_i  in  NumReq x num_t  operand A per requester.
- req_b_i  in  NumReq x num_t  operand B per requester.
- rsp_valid_o  out  NumReq  result valid; only the owner's bit is high.
- rsp_ready_i  in  NumReq  result accept per requester.
- rsp_result_o  out  num_t  shared result bus.
- alu_start_o  out  1  one-cycle start pulse.
- alu_op_o  out  OpWidth  latched op.
- alu_a_o, alu_b_o  out  num_t  latched operands.
- alu_done_i  in  1  one-cycle completion pulse.
- alu_result_i  in  num_t  valid when alu_done_i=1.
- busy_o  out  1  high whenever state is not IDLE.
- owner_o  out  $clog2(NumReq)  index of the current/last granted requester.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = 0 (requester 0 has top priority first).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o is high, combinationally, only for the highest-priority valid requester.
  - Priority search starts at the pointer and wraps modulo NumReq.
  - On valid&ready: latch op/a/b into the alu_* regs, latch owner_o, set pointer = owner+1 (wrapping), go to ISSUE.
- ISSUE: alu_start_o=1 for exactly this cycle; go to WAIT.
- WAIT:
  - On alu_done_i: capture alu_result_i into rsp_result_o and go to RESP.
  - alu_done_i is ignored in every state other than WAIT.
- RESP:
  - rsp_valid_o[owner]=1; rsp_result_o holds stable.
  - On rsp_ready_i[owner]: go to IDLE.
  - rsp_ready_i of non-owners is ignored.
- alu_op_o/alu_a_o/alu_b_o hold stable from ISSUE until the next accept.
- Latency, with the unit completing L cycles after start (L≥1):
  - accept at cycle t, start at t+1, done at t+1+L, rsp_valid from t+2+L.
  - Minimum accept-to-accept gap is 4 cycles.
- No request is accepted while busy_o=1; requesters must hold req_* stable until ready.
- Result fields, including error, pass through unmodified; the arbiter performs no arithmetic.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NumReq-1,0,…
- Reset mid-operation: return to IDLE with pointer 0 and all outputs 0; the in-flight result is discarded and a late alu_done_i is ignored.

Optional Feature:
- Macro: CALC_ALU_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TimeoutCycles without alu_done_i, go to RESP with rsp_result_o = num_t all zeros except error=1.
  - If alu_done_i arrives in the same cycle as the timeout, alu_done_i wins.
- When undefined: no counter; WAIT is held indefinitely until alu_done_i.

Test Plan:
- Single add: requester 0 sends op=0, A=1.0000000e0, B=2.0000000e0; stub unit with L=3 returns 3.0000000e0 → req_ready_o[0] at t, alu_start_o at t+1, rsp_valid_o[0] at t+5 with 3.0000000e0; ready at t+5 → busy_o=0 at t+6.
- Contention: both requesters valid at reset release → grants 0,1,0,1 over 4 operations; owner_o matches; rsp_valid_o never has both bits high.
- Backpressure: hold rsp_ready_i[1]=0 for 10 cycles in RESP → rsp_result_o stable; no new accept; requester 0 stays un-ready throughout.
- Error passthrough: stub returns div result with error=1 (1.0e0 / 0) → rsp_result_o.error=1; all other fields equal to the stub's output.
- Reset mid-WAIT: assert rst_i 2 cycles after alu_start_o; stub then pulses alu_done_i → no rsp_valid_o; next grant goes to requester 0.
- Timeout (CALC_ALU_ARB_TIMEOUT_EN, TimeoutCycles=8): stub never pulses done → RESP reached 8 cycles after entering WAIT; rsp_result_o.error=1, other fields 0.

Source files
------------

// File: rtl/calc_alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle calculator arithmetic unit between NumReq requesters.
// Optional WAIT watchdog enabled by defining CALC_ALU_ARB_TIMEOUT_EN.

package calc_pkg;

  typedef struct packed {
    logic        error;
    logic        sign;
    logic [7:0]  exponent;
    logic [31:0] mantissa;
  } num_t;

endpackage

module calc_alu_arbiter #(
  parameter int NumReq        = 2,
  parameter int OpWidth       = 2,
  parameter int TimeoutCycles = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumReq-1:0]                      req_valid_i,
  output logic [NumReq-1:0]                      req_ready_o,
  input  logic [NumReq-1:0][OpWidth-1:0]         req_op_i,
  input  calc_pkg::num_t [NumReq-1:0]            req_a_i,
  input  calc_pkg::num_t [NumReq-1:0]            req_b_i,
  output logic [NumReq-1:0]                      rsp_valid_o,
  input  logic [NumReq-1:0]                      rsp_ready_i,
  output calc_pkg::num_t                         rsp_result_o,
  output logic                                   alu_start_o,
  output logic [OpWidth-1:0]                     alu_op_o,
  output calc_pkg::num_t                         alu_a_o,
  output calc_pkg::num_t                         alu_b_o,
  input  logic                                   alu_done_i,
  input  calc_pkg::num_t                         alu_result_i,
  output logic                                   busy_o,
  output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0] owner_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  if (NumReq < 2 || NumReq > 4 || TimeoutCycles < 1) begin : g_bad_cfg
    $error("calc_alu_arbiter: NumReq must be 2..4 and TimeoutCycles at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_next;
  logic [IdxW-1:0]     owner_q;
  logic [IdxW-1:0]     grant_idx, cand_idx;
  logic                grant_found;
  logic                accept;
  int                  cand;
  logic [OpWidth-1:0]  alu_op_q;
  calc_pkg::num_t      alu_a_q, alu_b_q;
  calc_pkg::num_t      rsp_result_q, result_d;

`ifdef CALC_ALU_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam calc_pkg::num_t TimeoutResult = '{error: 1'b1, default: '0};
  logic [CntW-1:0] wait_cnt_q;
  logic            timed_out;

  assign timed_out = (wait_cnt_q == CntW'(TimeoutCycles - 1));

  // Counter starts from zero on the first WAIT cycle (cleared while in ISSUE).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`endif

  // Priority search begins at the round-robin pointer and wraps.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      cand_idx = IdxW'(cand);
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    if (grant_idx == IdxW'(NumReq - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    accept      = 1'b0;
    result_d    = rsp_result_q;
    case (state_q)
      IDLE: begin
        if (!rst_i && grant_found) begin
          req_ready_o[grant_idx] = 1'b1;
          accept                 = 1'b1;
          state_d                = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_done_i) begin
          result_d = alu_result_i;
          state_d  = RESP;
        end
`ifdef CALC_ALU_ARB_TIMEOUT_EN
        else if (timed_out) begin
          result_d = TimeoutResult;
          state_d  = RESP;
        end
`endif
      end
      RESP: begin
        if (rsp_ready_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      rsp_result_q <= result_d;
      if (accept) begin
        alu_op_q <= req_op_i[grant_idx];
        alu_a_q  <= req_a_i[grant_idx];
        alu_b_q  <= req_b_i[grant_idx];
        owner_q  <= grant_idx;
        ptr_q    <= ptr_next;
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP) begin
      rsp_valid_o[owner_q] = 1'b1;
    end
  end

  assign alu_start_o  = (state_q == ISSUE);
  assign busy_o       = (state_q != IDLE);
  assign alu_op_o     = alu_op_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign rsp_result_o = rsp_result_q;
  assign owner_o      = owner_q;

endmodule
